// File: rtl/tpu_pkg.sv
// Shared systolic-array types: element width, feeder FSM states, feed-length helper.
// Pure definitions; no latency or flow control of their own.
package tpu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

    typedef enum logic {
        IDLE = 1'b0,
        FEED = 1'b1
    } feeder_state_t;

    // Number of skewed slots needed: K + max(M, N) - 1, kept in 9 bits.
    function automatic logic [8:0] feed_len(
        input logic [7:0] k,
        input logic [7:0] m,
        input logic [7:0] n
    );
        logic [8:0] widest;
        widest = (m > n) ? {1'b0, m} : {1'b0, n};
        return {1'b0, k} + widest - 9'd1;
    endfunction

endpackage

// File: rtl/skew_lane.sv
// One operand lane: DEPTH-entry element buffer plus diagonal-window read for slot t.
// Write takes effect next edge; read is combinational; no backpressure (caller gates writes).
module skew_lane #(
    parameter int LANE_IDX   = 0,
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int K_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [K_W-1:0]        wr_k,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [8:0]            t,
    input  logic [7:0]            k,
    input  logic                  lane_enable,
    output logic [DATA_WIDTH-1:0] lane_dat
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  in_window;
    logic [K_W-1:0]        rd_idx;

    // Operand storage survives reset so a run can be replayed without reloading.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_k] <= wr_data;
        end
    end

    always_comb begin
        in_window = lane_enable
                 && (int'(t) >= LANE_IDX)
                 && (int'(t) < LANE_IDX + int'(k));
        rd_idx    = K_W'(int'(t) - LANE_IDX);
        lane_dat  = in_window ? mem[rd_idx] : '0;
    end

endmodule

// File: rtl/systolic_feeder.sv
// Stages A/B operands and streams them diagonally skewed into the array edges after start.
// First slot one cycle after start accepted; no backpressure, array consumes every slot.
module systolic_feeder #(
    parameter int ROW_NUMBER    = 4,
    parameter int COLUMN_NUMBER = 4,
    parameter int DATA_WIDTH    = tpu_pkg::DEFAULT_DATA_WIDTH,
    parameter int DEPTH         = 4,
    parameter int LANE_W        = $clog2((ROW_NUMBER > COLUMN_NUMBER) ? ROW_NUMBER : COLUMN_NUMBER),
    parameter int K_W           = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [LANE_W-1:0]     wr_lane,
    input  logic [K_W-1:0]        wr_k,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic [7:0]            size_row_A,
    input  logic [7:0]            size_column_B,
    input  logic [7:0]            size_columnrow_AB,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  feed_valid,
    output logic [DATA_WIDTH-1:0] left_in [0:ROW_NUMBER-1],
    output logic [DATA_WIDTH-1:0] top_in  [0:COLUMN_NUMBER-1]
);

    import tpu_pkg::*;

    feeder_state_t state, state_nx;

    logic [8:0] slot;
    logic [8:0] len_q;
    logic [7:0] m_q, n_q, k_q;

    logic       size_ok, accept, reject, last_slot, load_slot;
    logic [8:0] sel_t;
    logic [7:0] sel_m, sel_n, sel_k;
    logic       busy_nx, done_nx, err_nx;
    logic       wr_ok;

    logic [DATA_WIDTH-1:0] a_lane [ROW_NUMBER];
    logic [DATA_WIDTH-1:0] b_lane [COLUMN_NUMBER];

    // Next-state logic
    always_comb begin
        size_ok   = (int'(size_row_A) >= 1)        && (int'(size_row_A) <= ROW_NUMBER)
                 && (int'(size_column_B) >= 1)     && (int'(size_column_B) <= COLUMN_NUMBER)
                 && (int'(size_columnrow_AB) >= 1) && (int'(size_columnrow_AB) <= DEPTH);
        accept    = (state == IDLE) && start && size_ok;
        reject    = (state == IDLE) && start && !size_ok;
        last_slot = (state == FEED) && (slot == len_q - 9'd1);
        state_nx  = state;
        case (state)
            IDLE:    if (accept)    state_nx = FEED;
            FEED:    if (last_slot) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: selects the slot presented next cycle using the sizes that will apply to it.
    always_comb begin
        load_slot = accept || ((state == FEED) && !last_slot);
        sel_t     = accept ? 9'd0 : slot + 9'd1;
        sel_m     = accept ? size_row_A        : m_q;
        sel_n     = accept ? size_column_B     : n_q;
        sel_k     = accept ? size_columnrow_AB : k_q;
        busy_nx   = load_slot;
        done_nx   = last_slot;
        err_nx    = reject;
        wr_ok     = wr_en && (state == IDLE) && !accept && (int'(wr_k) < DEPTH);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            slot       <= 9'd0;
            len_q      <= 9'd0;
            m_q        <= 8'd0;
            n_q        <= 8'd0;
            k_q        <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            feed_valid <= 1'b0;
            for (int r = 0; r < ROW_NUMBER; r++) begin
                left_in[r] <= '0;
            end
            for (int c = 0; c < COLUMN_NUMBER; c++) begin
                top_in[c] <= '0;
            end
        end else begin
            state <= state_nx;
            if (accept) begin
                m_q   <= size_row_A;
                n_q   <= size_column_B;
                k_q   <= size_columnrow_AB;
                len_q <= feed_len(size_columnrow_AB, size_row_A, size_column_B);
            end
            slot       <= load_slot ? sel_t : 9'd0;
            busy       <= busy_nx;
            feed_valid <= busy_nx;
            done       <= done_nx;
            err        <= err_nx;
            for (int r = 0; r < ROW_NUMBER; r++) begin
                left_in[r] <= load_slot ? a_lane[r] : '0;
            end
            for (int c = 0; c < COLUMN_NUMBER; c++) begin
                top_in[c] <= load_slot ? b_lane[c] : '0;
            end
        end
    end

    for (genvar r = 0; r < ROW_NUMBER; r++) begin : g_a_lane
        skew_lane #(
            .LANE_IDX   (r),
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH),
            .K_W        (K_W)
        ) u_lane (
            .clk         (clk),
            .wr_en       (wr_ok && !wr_sel && (int'(wr_lane) == r)),
            .wr_k        (wr_k),
            .wr_data     (wr_data),
            .t           (sel_t),
            .k           (sel_k),
            .lane_enable (r < int'(sel_m)),
            .lane_dat    (a_lane[r])
        );
    end

    for (genvar c = 0; c < COLUMN_NUMBER; c++) begin : g_b_lane
        skew_lane #(
            .LANE_IDX   (c),
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH),
            .K_W        (K_W)
        ) u_lane (
            .clk         (clk),
            .wr_en       (wr_ok && wr_sel && (int'(wr_lane) == c)),
            .wr_k        (wr_k),
            .wr_data     (wr_data),
            .t           (sel_t),
            .k           (sel_k),
            .lane_enable (c < int'(sel_n)),
            .lane_dat    (b_lane[c])
        );
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized and directed bench for systolic_feeder against a matrix-level reference model.
module tb_systolic_feeder;

    localparam int RN = 4;
    localparam int CN = 4;
    localparam int DP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic       wr_sel;
    logic [1:0] wr_lane;
    logic [1:0] wr_k;
    logic [7:0] wr_data;
    logic       start;
    logic [7:0] size_row_A;
    logic [7:0] size_column_B;
    logic [7:0] size_columnrow_AB;
    logic       busy;
    logic       done;
    logic       err;
    logic       feed_valid;
    logic [7:0] left_in [0:RN-1];
    logic [7:0] top_in  [0:CN-1];

    int checks = 0;
    int errors = 0;

    // Reference matrices: a_mdl[r][k] = A[r][k], b_mdl[k][c] = B[k][c]
    logic [7:0] a_mdl [RN][DP];
    logic [7:0] b_mdl [DP][CN];

    always #5 clk = ~clk;

    systolic_feeder #(
        .ROW_NUMBER    (RN),
        .COLUMN_NUMBER (CN),
        .DATA_WIDTH    (8),
        .DEPTH         (DP)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .wr_en             (wr_en),
        .wr_sel            (wr_sel),
        .wr_lane           (wr_lane),
        .wr_k              (wr_k),
        .wr_data           (wr_data),
        .start             (start),
        .size_row_A        (size_row_A),
        .size_column_B     (size_column_B),
        .size_columnrow_AB (size_columnrow_AB),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .feed_valid        (feed_valid),
        .left_in           (left_in),
        .top_in            (top_in)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Row r of A enters the west edge delayed by r cycles; column c of B enters north delayed by c.
    function automatic logic [7:0] exp_left(int r, int t, int m, int kk);
        if (r < m && t - r >= 0 && t - r < kk) return a_mdl[r][t-r];
        return 8'd0;
    endfunction

    function automatic logic [7:0] exp_top(int c, int t, int n, int kk);
        if (c < n && t - c >= 0 && t - c < kk) return b_mdl[t-c][c];
        return 8'd0;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_fv"}, 32'(feed_valid), 32'd0);
        for (int i = 0; i < RN; i++) check($sformatf("%s_left%0d", tag, i), 32'(left_in[i]), 32'd0);
        for (int i = 0; i < CN; i++) check($sformatf("%s_top%0d", tag, i), 32'(top_in[i]), 32'd0);
    endtask

    task automatic write_elem(input bit sel, input int lane, input int kk, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_lane = 2'(lane);
        wr_k    = 2'(kk);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (sel) b_mdl[kk][lane] = d;
        else     a_mdl[lane][kk] = d;
    endtask

    // Issues start in the current cycle and checks every slot; returns in the done cycle.
    task automatic run_feed(input int m, input int n, input int kk, input bit disturb, input string tag);
        int len;
        len = kk + ((m > n) ? m : n) - 1;
        size_row_A        = 8'(m);
        size_column_B     = 8'(n);
        size_columnrow_AB = 8'(kk);
        start             = 1'b1;
        if (disturb) begin
            wr_en   = 1'b1;
            wr_sel  = 1'($urandom_range(0, 1));
            wr_lane = 2'($urandom_range(0, 3));
            wr_k    = 2'($urandom_range(0, 3));
            wr_data = 8'($urandom);
        end
        tick();
        for (int t = 0; t < len; t++) begin
            if (disturb) begin
                start             = 1'b1;
                size_row_A        = 8'($urandom_range(1, RN));
                size_column_B     = 8'($urandom_range(1, CN));
                size_columnrow_AB = 8'($urandom_range(1, DP));
                wr_en             = 1'b1;
                wr_sel            = 1'($urandom_range(0, 1));
                wr_lane           = 2'($urandom_range(0, 3));
                wr_k              = 2'($urandom_range(0, 3));
                wr_data           = 8'($urandom);
            end else begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            check($sformatf("%s_busy_t%0d", tag, t), 32'(busy), 32'd1);
            check($sformatf("%s_fv_t%0d", tag, t), 32'(feed_valid), 32'd1);
            check($sformatf("%s_done_t%0d", tag, t), 32'(done), 32'd0);
            check($sformatf("%s_err_t%0d", tag, t), 32'(err), 32'd0);
            for (int r = 0; r < RN; r++)
                check($sformatf("%s_left%0d_t%0d", tag, r, t), 32'(left_in[r]), 32'(exp_left(r, t, m, kk)));
            for (int c = 0; c < CN; c++)
                check($sformatf("%s_top%0d_t%0d", tag, c, t), 32'(top_in[c]), 32'(exp_top(c, t, n, kk)));
            tick();
        end
        start = 1'b0;
        wr_en = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_done_err"}, 32'(err), 32'd0);
        check_quiet({tag, "_donecyc"});
    endtask

    initial begin
        int bad [4][3];
        reset             = 1'b1;
        wr_en             = 1'b0;
        wr_sel            = 1'b0;
        wr_lane           = 2'd0;
        wr_k              = 2'd0;
        wr_data           = 8'd0;
        start             = 1'b0;
        size_row_A        = 8'd0;
        size_column_B     = 8'd0;
        size_columnrow_AB = 8'd0;
        for (int r = 0; r < RN; r++) for (int k = 0; k < DP; k++) a_mdl[r][k] = 8'd0;
        for (int k = 0; k < DP; k++) for (int c = 0; c < CN; c++) b_mdl[k][c] = 8'd0;
        tick(); tick(); tick();
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check_quiet("rst");
        reset = 1'b0;

        // Small 2x3 * 3x1 case
        for (int k = 0; k < 3; k++) begin
            write_elem(1'b0, 0, k, 8'(k + 1));
            write_elem(1'b0, 1, k, 8'(k + 4));
            write_elem(1'b1, 0, k, 8'(k + 7));
        end
        run_feed(2, 1, 3, 1'b0, "small");
        tick();
        check("small_done_pulse", 32'(done), 32'd0);

        // Full 4x4x4 with arithmetic contents
        for (int r = 0; r < RN; r++) for (int k = 0; k < DP; k++) write_elem(1'b0, r, k, 8'(4 * r + k + 1));
        for (int k = 0; k < DP; k++) for (int c = 0; c < CN; c++) write_elem(1'b1, c, k, 8'(16 + 4 * k + c));
        run_feed(4, 4, 4, 1'b0, "full");
        tick();

        // Rejected starts: {M, N, K}
        bad[0] = '{1, 1, 0};
        bad[1] = '{5, 1, 1};
        bad[2] = '{2, 0, 2};
        bad[3] = '{1, 4, 5};
        for (int i = 0; i < 4; i++) begin
            size_row_A        = 8'(bad[i][0]);
            size_column_B     = 8'(bad[i][1]);
            size_columnrow_AB = 8'(bad[i][2]);
            start             = 1'b1;
            tick();
            start = 1'b0;
            check($sformatf("bad%0d_err", i), 32'(err), 32'd1);
            check($sformatf("bad%0d_done", i), 32'(done), 32'd0);
            check_quiet($sformatf("bad%0d", i));
            tick();
            check($sformatf("bad%0d_err_clr", i), 32'(err), 32'd0);
            check_quiet($sformatf("bad%0d_after", i));
        end

        // Writes and starts during FEED are dropped; back-to-back run replays original buffers
        run_feed(4, 4, 4, 1'b1, "dist");
        run_feed(3, 2, 4, 1'b0, "b2b");
        tick();
        check("b2b_idle_done", 32'(done), 32'd0);

        // Reset mid-feed
        size_row_A        = 8'd4;
        size_column_B     = 8'd4;
        size_columnrow_AB = 8'd4;
        start             = 1'b1;
        tick();
        start = 1'b0;
        check("rstmid_left0_t0", 32'(left_in[0]), 32'(a_mdl[0][0]));
        tick();
        check("rstmid_busy_c2", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_err", 32'(err), 32'd0);
        check_quiet("rstmid");
        tick();
        check("rstmid_done_later", 32'(done), 32'd0);
        check_quiet("rstmid_later");
        run_feed(4, 4, 4, 1'b0, "replay");
        tick();

        // Random contents and sizes, some disturbed, some back-to-back
        for (int it = 0; it < 15; it++) begin
            for (int w = 0; w < 6; w++)
                write_elem(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom));
            run_feed($urandom_range(1, RN), $urandom_range(1, CN), $urandom_range(1, DP),
                     1'($urandom_range(0, 1)), $sformatf("rnd%0d", it));
            if ($urandom_range(0, 1) == 1) run_feed($urandom_range(1, RN), $urandom_range(1, CN),
                                                    $urandom_range(1, DP), 1'b0, $sformatf("rndb%0d", it));
            tick();
        end
        check_quiet("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Input staging and skew stage that sits directly upstream of the systolic `array`. It buffers one A operand (row-major, per row lane) and one B operand (column-major, per column lane), then streams them into `left_in` / `top_in` with a one-cycle-per-lane diagonal skew, zero-padding everywhere else. It replaces ad-hoc input generation driven by a free-running counter with a start/busy/done handshake, so the array can be clocked continuously.

## Interface
- `ROW_NUMBER`, 4, array rows = number of `left_in` lanes
- `COLUMN_NUMBER`, 4, array columns = number of `top_in` lanes
- `DATA_WIDTH`, 8, operand element width
- `DEPTH`, 4, maximum inner dimension K held per lane
- `LANE_W`, derived: $clog2(max(ROW_NUMBER, COLUMN_NUMBER)); `K_W`, derived: $clog2(DEPTH)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `wr_en`  in  1  buffer write strobe
- `wr_sel`  in  1  0 = A buffer, 1 = B buffer
- `wr_lane`  in  LANE_W  A row index / B column index
- `wr_k`  in  K_W  inner-dimension index
- `wr_data`  in  DATA_WIDTH  element
- `start`  in  1  launch feed, sampled in IDLE only
- `size_row_A`  in  8  M, rows of A used
- `size_column_B`  in  8  N, columns of B used
- `size_columnrow_AB`  in  8  K, inner dimension
- `busy`  out  1  feed in progress
- `done`  out  1  one-cycle pulse after last feed slot
- `err`  out  1  one-cycle pulse, start rejected
- `feed_valid`  out  1  `left_in`/`top_in` carry a feed slot
- `left_in[0:ROW_NUMBER-1]`  out  DATA_WIDTH each  to array west edge
- `top_in[0:COLUMN_NUMBER-1]`  out  DATA_WIDTH each  to array north edge

## Operation
- Buffers: `A_buf[r][k]` = A[r][k]; `B_buf[c][k]` = B[k][c]. Contents not cleared by reset; retained across runs.
- Writes accepted only in IDLE with no start accepted that cycle; otherwise dropped. Writes with `wr_lane` ≥ the lane count of the selected buffer, or `wr_k` ≥ DEPTH, are dropped.
- States: IDLE, FEED. IDLE→FEED on legal `start`. FEED→IDLE after L slots.
- Legal start: 1≤M≤ROW_NUMBER, 1≤N≤COLUMN_NUMBER, 1≤K≤DEPTH. Illegal: stay IDLE, `err` pulse next cycle.
- On accept: latch M, N, K; L = K + max(M,N) − 1 (9-bit arithmetic); slot counter t = 0.
- Slot t: `left_in[r]` = A_buf[r][t−r] if r<M and r≤t<r+K, else 0; `top_in[c]` = B_buf[c][t−c] if c<N and c≤t<c+K, else 0. Lanes ≥ M / ≥ N are always 0.
- `start` during FEED is ignored (no `err`).

## Timing
- Reset: state IDLE; `busy`, `done`, `err`, `feed_valid` = 0; all `left_in`/`top_in` = 0.
- All outputs are registered. Start accepted at the edge ending cycle 0 → cycles 1..L present slots t = 0..L−1 with `busy` = `feed_valid` = 1.
- Cycle L+1: `busy` = 0, `done` = 1, lanes 0. A new `start` in cycle L+1 is accepted (back-to-back, slot 0 in cycle L+2).
- Outside FEED all lanes are 0 and `feed_valid` = 0.
- Reset mid-FEED: next cycle IDLE with all outputs 0, no `done`.
- `err` asserted the cycle after the rejected start; at most one of `done`/`err` pulses per cycle.

## Structure
- Shared package `tpu_pkg`: `DATA_WIDTH` default, `data_t` typedef, `feeder_state_t` enum {IDLE, FEED}; reused by `array` and the downstream drain.
- One sub-module `skew_lane` (per-lane buffer + slot selector: params LANE_IDX, DEPTH; inputs t, K, lane_enable), instantiated ROW_NUMBER times for A and COLUMN_NUMBER times for B.

## Test plan
- Load A=[[1,2,3],[4,5,6]], B column 0=[7,8,9]; start M=2,N=1,K=3 → L=4; cycles 1–4: `left_in[0]`=1,2,3,0; `left_in[1]`=0,4,5,6; `top_in[0]`=7,8,9,0; other lanes 0; `done` in cycle 5.
- Full 4×4×4 with A[r][k]=4r+k+1, B[k][c]=16+4k+c → L=7; `left_in[3]` = 0,0,0,13,14,15,16; `top_in[3]` = 0,0,0,19,23,27,31.
- Start with K=0, then M=5 → no `busy`, `err` pulse each, outputs stay 0.
- Writes and a second `start` issued during FEED → dropped; re-run in IDLE shows original buffer data; back-to-back start in `done` cycle yields slot 0 in the following cycle.
- Assert `reset` in cycle 2 of a 4×4×4 feed → cycle 3: all outputs 0, IDLE; no `done`; subsequent start replays the retained buffers.
